// File: rtl/watch_pkg.sv
// Shared constants and helpers for the watch datapath.
package watch_pkg;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HOUR_W   = 5;

  // 0 -> 12, 13..23 -> 1..11, 1..12 unchanged
  function automatic logic [HOUR_W-1:0] hour_to_12h(input logic [HOUR_W-1:0] h);
    if (h == '0)             return HOUR_W'(12);
    else if (h > HOUR_W'(12)) return h - HOUR_W'(12);
    else                     return h;
  endfunction
endpackage

// File: rtl/watch_dp_gen_if.sv
// Control/time bus between the control FSM (master) and the watch datapath (slave).
interface watch_dp_gen_if
  import watch_pkg::*;
#(
  parameter int SUBSEC_HZ = 100
);
  localparam int SSW = $clog2(SUBSEC_HZ);

  logic              run, mode_12h, load;
  logic              inc_sec, inc_min, inc_hour;
  logic              dec_sec, dec_min, dec_hour;
  logic [HOUR_W-1:0] ld_hour;
  logic [MIN_W-1:0]  ld_min;
  logic [SEC_W-1:0]  ld_sec;
  logic              alarm_set, alarm_arm;
  logic [SSW-1:0]    subsec;
  logic [SEC_W-1:0]  sec;
  logic [MIN_W-1:0]  min;
  logic [HOUR_W-1:0] hour;
  logic              pm, sec_tick, day_tick, alarm_hit;

  modport master (
    output run, mode_12h, load, inc_sec, inc_min, inc_hour, dec_sec, dec_min, dec_hour,
           ld_hour, ld_min, ld_sec, alarm_set, alarm_arm,
    input  subsec, sec, min, hour, pm, sec_tick, day_tick, alarm_hit
  );
  modport slave (
    input  run, mode_12h, load, inc_sec, inc_min, inc_hour, dec_sec, dec_min, dec_hour,
           ld_hour, ld_min, ld_sec, alarm_set, alarm_arm,
    output subsec, sec, min, hour, pm, sec_tick, day_tick, alarm_hit
  );
endinterface

// File: rtl/watch_field_counter.sv
// One time field: wraps 0..MAX; priority load > inc/dec (no carry) > carry_in.
module watch_field_counter #(
  parameter int W         = 6,
  parameter int MAX       = 59,
  parameter int RESET_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         carry_in,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic [W-1:0] nxt,
  output logic         carry_out
);
  localparam logic [W-1:0] MAXV = W'(MAX);
  localparam logic [W-1:0] RSTV = W'(RESET_VAL);

  logic at_max, at_zero;
  assign at_max  = (value == MAXV);
  assign at_zero = (value == '0);

  always_comb begin
    nxt       = value;
    carry_out = 1'b0;
    if (load) begin
      nxt = (load_val > MAXV) ? '0 : load_val;
    end else if (inc | dec) begin
      // inc and dec together cancel; an adjusted field swallows its carry-in
      if (inc & ~dec)      nxt = at_max  ? '0   : value + 1'b1;
      else if (dec & ~inc) nxt = at_zero ? MAXV : value - 1'b1;
    end else if (carry_in) begin
      carry_out = at_max;
      nxt       = at_max ? '0 : value + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= RSTV;
    else        value <= nxt;
endmodule

// File: rtl/watch_dp_gen.sv
// Time-of-day datapath: prescaler + subsec/sec/min/hour carry chain, adjust, load, 12/24h.
// Optional alarm enabled by defining WATCH_ALARM_EN.
module watch_dp_gen
  import watch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int SUBSEC_HZ  = 100,
  parameter int RESET_HOUR = 12,
  parameter int RESET_MIN  = 0,
  parameter int RESET_SEC  = 0
) (
  input logic          clk,
  input logic          rst_n,
  watch_dp_gen_if.slave bus
);
  localparam int PRESC = CLK_HZ / SUBSEC_HZ;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int SSW   = $clog2(SUBSEC_HZ);

  logic [PW-1:0]     presc;
  logic              sub_tick;
  logic              ss_co, sec_co, min_co, hour_co;
  logic [SSW-1:0]    ss_val, ss_nxt;
  logic [SEC_W-1:0]  sec_val, sec_nxt;
  logic [MIN_W-1:0]  min_val, min_nxt;
  logic [HOUR_W-1:0] hour_val, hour_nxt;
  logic              sec_tick_q, day_tick_q;

  assign sub_tick = bus.run && !bus.load && (presc == PW'(PRESC - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       presc <= '0;
    else if (bus.load) presc <= '0;
    else if (bus.run)  presc <= sub_tick ? '0 : presc + 1'b1;

  watch_field_counter #(.W(SSW), .MAX(SUBSEC_HZ - 1), .RESET_VAL(0)) u_subsec (
    .clk(clk), .rst_n(rst_n), .carry_in(sub_tick), .inc(1'b0), .dec(1'b0),
    .load(bus.load), .load_val('0), .value(ss_val), .nxt(ss_nxt), .carry_out(ss_co));

  watch_field_counter #(.W(SEC_W), .MAX(SEC_MAX), .RESET_VAL(RESET_SEC)) u_sec (
    .clk(clk), .rst_n(rst_n), .carry_in(ss_co), .inc(bus.inc_sec), .dec(bus.dec_sec),
    .load(bus.load), .load_val(bus.ld_sec), .value(sec_val), .nxt(sec_nxt), .carry_out(sec_co));

  watch_field_counter #(.W(MIN_W), .MAX(MIN_MAX), .RESET_VAL(RESET_MIN)) u_min (
    .clk(clk), .rst_n(rst_n), .carry_in(sec_co), .inc(bus.inc_min), .dec(bus.dec_min),
    .load(bus.load), .load_val(bus.ld_min), .value(min_val), .nxt(min_nxt), .carry_out(min_co));

  watch_field_counter #(.W(HOUR_W), .MAX(HOUR_MAX), .RESET_VAL(RESET_HOUR)) u_hour (
    .clk(clk), .rst_n(rst_n), .carry_in(min_co), .inc(bus.inc_hour), .dec(bus.dec_hour),
    .load(bus.load), .load_val(bus.ld_hour), .value(hour_val), .nxt(hour_nxt), .carry_out(hour_co));

  // sec_tick only when sec moves by carry; an adjusted sec blocks it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      sec_tick_q <= ss_co & ~(bus.inc_sec | bus.dec_sec);
      day_tick_q <= hour_co;
    end

  assign bus.subsec   = ss_val;
  assign bus.sec      = sec_val;
  assign bus.min      = min_val;
  assign bus.hour     = bus.mode_12h ? hour_to_12h(hour_val) : hour_val;
  assign bus.pm       = (hour_val >= HOUR_W'(12));
  assign bus.sec_tick = sec_tick_q;
  assign bus.day_tick = day_tick_q;

`ifdef WATCH_ALARM_EN
  logic [HOUR_W-1:0] al_hour;
  logic [MIN_W-1:0]  al_min;
  logic              hit_q;

  // compare against the post-carry time so the hit lands with hh:mm:00
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      al_hour <= '0;
      al_min  <= '0;
      hit_q   <= 1'b0;
    end else begin
      if (bus.alarm_set) begin
        al_hour <= bus.ld_hour;
        al_min  <= bus.ld_min;
      end
      hit_q <= sec_co && bus.alarm_arm && (min_nxt == al_min) && (hour_nxt == al_hour);
    end

  assign bus.alarm_hit = hit_q;
  wire unused_nxt = &{1'b0, ss_nxt, sec_nxt};
`else
  assign bus.alarm_hit = 1'b0;
  wire unused_alarm = &{1'b0, bus.alarm_set, bus.alarm_arm, ss_nxt, sec_nxt, min_nxt, hour_nxt};
`endif
endmodule

// File: tb/tb_watch_dp_gen.sv
// Directed bench for watch_dp_gen at CLK_HZ=1000, SUBSEC_HZ=100 (prescale 10).
module tb_watch_dp_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  watch_dp_gen_if #(.SUBSEC_HZ(100)) bus ();

  watch_dp_gen #(
    .CLK_HZ(1000), .SUBSEC_HZ(100), .RESET_HOUR(12), .RESET_MIN(0), .RESET_SEC(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [4:0] ld_hour;
    logic [5:0] ld_min;
    logic [5:0] ld_sec;
    logic       mode;
    int         exp_hour;
    int         exp_pm;
    int         exp_min;
    int         exp_sec;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    bus.ld_hour = 5'(h);
    bus.ld_min  = 6'(m);
    bus.ld_sec  = 6'(s);
    bus.load    = 1'b1;
    step(1);
    bus.load    = 1'b0;
  endtask

  task automatic chk_time(input string nm, input int h, input int m, input int s, input int ss);
    chk({nm, ".hour"}, 32'(bus.hour), h);
    chk({nm, ".min"}, 32'(bus.min), m);
    chk({nm, ".sec"}, 32'(bus.sec), s);
    chk({nm, ".subsec"}, 32'(bus.subsec), ss);
  endtask

  initial begin
    int hits, first;
    bus.run = 0; bus.mode_12h = 0; bus.load = 0;
    bus.inc_sec = 0; bus.inc_min = 0; bus.inc_hour = 0;
    bus.dec_sec = 0; bus.dec_min = 0; bus.dec_hour = 0;
    bus.ld_hour = 0; bus.ld_min = 0; bus.ld_sec = 0;
    bus.alarm_set = 0; bus.alarm_arm = 0;

    vt[0] = '{5'd0,  6'd0,  6'd0,  1'b1, 12, 0, 0,  0};
    vt[1] = '{5'd0,  6'd0,  6'd0,  1'b0, 0,  0, 0,  0};
    vt[2] = '{5'd13, 6'd5,  6'd7,  1'b1, 1,  1, 5,  7};
    vt[3] = '{5'd12, 6'd1,  6'd2,  1'b1, 12, 1, 1,  2};
    vt[4] = '{5'd23, 6'd59, 6'd59, 1'b0, 23, 1, 59, 59};
    vt[5] = '{5'd25, 6'd60, 6'd61, 1'b0, 0,  0, 0,  0};
    vt[6] = '{5'd11, 6'd59, 6'd59, 1'b1, 11, 0, 59, 59};
    vt[7] = '{5'd24, 6'd30, 6'd10, 1'b1, 12, 0, 30, 10};

    // reset state
    step(2);
    chk_time("rst", 12, 0, 0, 0);
    chk("rst.pm", 32'(bus.pm), 1);
    chk("rst.sec_tick", 32'(bus.sec_tick), 0);
    chk("rst.day_tick", 32'(bus.day_tick), 0);
    chk("rst.alarm_hit", 32'(bus.alarm_hit), 0);
    bus.mode_12h = 1; #1;
    chk("rst.hour12", 32'(bus.hour), 12);
    chk("rst.pm12", 32'(bus.pm), 1);
    bus.mode_12h = 0;

    // count, then asynchronous reset mid-count
    rst_n = 1; bus.run = 1;
    step(25);
    chk("run.subsec", 32'(bus.subsec), 2);
    #2 rst_n = 0; #1;
    chk_time("midrst", 12, 0, 0, 0);
    step(1);
    rst_n = 1;
    step(10);
    chk_time("restart", 12, 0, 0, 1);
    bus.run = 0;

    // table: parallel load, range clamp, 12/24 h display
    for (int i = 0; i < 8; i++) begin
      bus.mode_12h = vt[i].mode;
      do_load(int'(vt[i].ld_hour), int'(vt[i].ld_min), int'(vt[i].ld_sec));
      chk_time($sformatf("vec%0d", i), vt[i].exp_hour, vt[i].exp_min, vt[i].exp_sec, 0);
      chk($sformatf("vec%0d.pm", i), 32'(bus.pm), vt[i].exp_pm);
    end

    // day rollover
    bus.mode_12h = 0; bus.run = 1;
    do_load(23, 59, 59);
    step(999);
    chk_time("pre_day", 23, 59, 59, 99);
    chk("pre_day.day_tick", 32'(bus.day_tick), 0);
    step(1);
    chk_time("day", 0, 0, 0, 0);
    chk("day.day_tick", 32'(bus.day_tick), 1);
    chk("day.sec_tick", 32'(bus.sec_tick), 1);
    bus.mode_12h = 1; #1;
    chk("day.hour12", 32'(bus.hour), 12);
    chk("day.pm", 32'(bus.pm), 0);
    step(1);
    chk("post_day.day_tick", 32'(bus.day_tick), 0);
    chk("post_day.sec_tick", 32'(bus.sec_tick), 0);
    bus.mode_12h = 0; bus.run = 0;

    // adjusts wrap inside the field only
    do_load(10, 0, 30);
    bus.dec_min = 1; step(1); bus.dec_min = 0;
    chk_time("dec_min", 10, 59, 30, 0);
    bus.inc_sec = 1; bus.dec_sec = 1; step(1); bus.inc_sec = 0; bus.dec_sec = 0;
    chk("incdec.sec", 32'(bus.sec), 30);
    do_load(0, 0, 0);
    bus.dec_hour = 1; bus.dec_sec = 1; step(1); bus.dec_hour = 0; bus.dec_sec = 0;
    chk_time("dec_wrap", 23, 0, 59, 0);
    bus.inc_hour = 1; step(1); bus.inc_hour = 0;
    chk("inc_hour.wrap", 32'(bus.hour), 0);

    // inc_sec coinciding with the subsec wrap at sec=59
    bus.run = 1;
    do_load(10, 20, 59);
    step(999);
    chk_time("pre_inc", 10, 20, 59, 99);
    bus.inc_sec = 1; step(1); bus.inc_sec = 0;
    chk_time("inc_carry", 10, 20, 0, 0);
    chk("inc_carry.sec_tick", 32'(bus.sec_tick), 0);
    step(1);
    chk("inc_carry.sec_tick2", 32'(bus.sec_tick), 0);
    bus.run = 0;

    // out-of-range load then freeze
    do_load(25, 60, 10);
    step(5000);
    chk_time("frozen", 0, 0, 10, 0);
    bus.run = 1;
    step(10);
    chk("thaw.subsec", 32'(bus.subsec), 1);
    bus.run = 0;

    // alarm: armed run, then disarmed run
    bus.ld_hour = 7; bus.ld_min = 30; bus.alarm_set = 1; step(1); bus.alarm_set = 0;
    for (int pass = 0; pass < 2; pass++) begin
      bus.alarm_arm = (pass == 0);
      bus.run = 1;
      do_load(7, 29, 59);
      hits = 0; first = 0;
      for (int i = 1; i <= 1100; i++) begin
        step(1);
        if (bus.alarm_hit === 1'b1) begin
          hits++;
          if (first == 0) first = i;
        end
      end
`ifdef WATCH_ALARM_EN
      chk($sformatf("alarm%0d.hits", pass), 32'(hits), (pass == 0) ? 1 : 0);
      chk($sformatf("alarm%0d.first", pass), 32'(first), (pass == 0) ? 1000 : 0);
`else
      chk($sformatf("alarm%0d.hits", pass), 32'(hits), 0);
`endif
      chk($sformatf("alarm%0d.min", pass), 32'(bus.min), 30);
      chk($sformatf("alarm%0d.hour", pass), 32'(bus.hour), 7);
    end
    bus.run = 0; bus.alarm_arm = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
